fa_selftest_checker: RTL and testbench

//  Synthesizable response-side partner of the full-adder stimulus sequence: drives all 8
//  {A,B,Cin} vectors into an external full adder and samples its S/Cout.

---
 rtl/fa_selftest_checker.sv | 188 ++++++++++++++++++
 tb/tb_fa_selftest_checker.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa_selftest_checker.sv
// Built-in self-test partner for a 1-bit full adder: sweeps all 8 {A,B,Cin} vectors, samples S/Cout,
// counts mismatches against a golden result. Define FA_FIRST_FAIL_CAPTURE_EN to add first-failure capture.
module fa_selftest_checker #(
    parameter int NUM_PASSES    = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 4
) (
    input  logic                 clk_input,
    input  logic                 reset_input,
    input  logic                 start_input,
    input  logic                 S_sense,
    input  logic                 Cout_sense,
    output logic                 A_drive,
    output logic                 B_drive,
    output logic                 Cin_drive,
    output logic                 busy_output,
    output logic                 done_output,
    output logic                 pass_output,
    output logic [ERR_CNT_W-1:0] err_cnt_output,
`ifdef FA_FIRST_FAIL_CAPTURE_EN
    output logic [2:0]           fail_vec_output,
    output logic                 fail_S_output,
    output logic                 fail_Cout_output,
    output logic                 fail_valid_output,
`endif
    output logic [1:0]           fsm_state_output
);

    // Handshake: start_input is a single-cycle request, accepted only in IDLE or DONE;
    // a run is in flight while busy_output=1, and done_output/pass_output hold until the next accepted start.

    localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [PASS_W-1:0]    LAST_PASS   = PASS_W'(NUM_PASSES - 1);
    localparam logic [SET_W-1:0]     SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [2:0]             vec_q, vec_d;
    logic [PASS_W-1:0]      pass_idx_q, pass_idx_d;
    logic [SET_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic                   exp_s, exp_c, mismatch;
`ifdef FA_FIRST_FAIL_CAPTURE_EN
    logic [2:0]             fail_vec_q, fail_vec_d;
    logic                   fail_s_q, fail_s_d;
    logic                   fail_cout_q, fail_cout_d;
    logic                   fail_valid_q, fail_valid_d;
`endif

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        pass_idx_d   = pass_idx_q;
        settle_cnt_d = settle_cnt_q;
        err_cnt_d    = err_cnt_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
`ifdef FA_FIRST_FAIL_CAPTURE_EN
        fail_vec_d   = fail_vec_q;
        fail_s_d     = fail_s_q;
        fail_cout_d  = fail_cout_q;
        fail_valid_d = fail_valid_q;
`endif
        // vec is {A,B,Cin}
        exp_s    = vec_q[2] ^ vec_q[1] ^ vec_q[0];
        exp_c    = (vec_q[2] & vec_q[1]) | (vec_q[0] & (vec_q[2] ^ vec_q[1]));
        mismatch = (state_q == ST_CHECK) && ((S_sense != exp_s) || (Cout_sense != exp_c));

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_input) begin
                    state_d      = ST_SETTLE;
                    vec_d        = 3'd0;
                    pass_idx_d   = '0;
                    err_cnt_d    = '0;
                    settle_cnt_d = SETTLE_LOAD;
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
`ifdef FA_FIRST_FAIL_CAPTURE_EN
                    fail_vec_d   = 3'd0;
                    fail_s_d     = 1'b0;
                    fail_cout_d  = 1'b0;
                    fail_valid_d = 1'b0;
`endif
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end
            ST_CHECK: begin
                if (mismatch && (err_cnt_q != ERR_MAX)) begin
                    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                end
`ifdef FA_FIRST_FAIL_CAPTURE_EN
                if (mismatch && !fail_valid_q) begin
                    fail_vec_d   = vec_q;
                    fail_s_d     = S_sense;
                    fail_cout_d  = Cout_sense;
                    fail_valid_d = 1'b1;
                end
`endif
                if ((vec_q == 3'd7) && (pass_idx_q == LAST_PASS)) begin
                    // Verdict includes the result of this final check.
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d      = ST_SETTLE;
                    vec_d        = vec_q + 3'd1;
                    settle_cnt_d = SETTLE_LOAD;
                    if (vec_q == 3'd7) begin
                        pass_idx_d = pass_idx_q + PASS_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_input or posedge reset_input) begin
        if (reset_input) begin
            state_q      <= ST_IDLE;
            vec_q        <= 3'd0;
            pass_idx_q   <= '0;
            settle_cnt_q <= '0;
            err_cnt_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef FA_FIRST_FAIL_CAPTURE_EN
            fail_vec_q   <= 3'd0;
            fail_s_q     <= 1'b0;
            fail_cout_q  <= 1'b0;
            fail_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            pass_idx_q   <= pass_idx_d;
            settle_cnt_q <= settle_cnt_d;
            err_cnt_q    <= err_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
`ifdef FA_FIRST_FAIL_CAPTURE_EN
            fail_vec_q   <= fail_vec_d;
            fail_s_q     <= fail_s_d;
            fail_cout_q  <= fail_cout_d;
            fail_valid_q <= fail_valid_d;
`endif
        end
    end

    // vec is 0 in IDLE and frozen at 7 in DONE, so the drives follow it directly.
    assign A_drive          = vec_q[2];
    assign B_drive          = vec_q[1];
    assign Cin_drive        = vec_q[0];
    assign busy_output      = busy_q;
    assign done_output      = done_q;
    assign pass_output      = pass_q;
    assign err_cnt_output   = err_cnt_q;
    assign fsm_state_output = state_q;
`ifdef FA_FIRST_FAIL_CAPTURE_EN
    assign fail_vec_output   = fail_vec_q;
    assign fail_S_output     = fail_s_q;
    assign fail_Cout_output  = fail_cout_q;
    assign fail_valid_output = fail_valid_q;
`endif

endmodule

// File: tb/tb_fa_selftest_checker.sv
// Bench for fa_selftest_checker: two instances (defaults, and NUM_PASSES=2/SETTLE_CYCLES=3/ERR_CNT_W=2)
// each facing a modelled external full adder with selectable faults.
module tb_fa_selftest_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start1, start2;

    logic       a1, b1, ci1, s1, co1, busy1, done1, pass1;
    logic [3:0] err1;
    logic [1:0] st1, fa1;
    logic       a2, b2, ci2, s2, co2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [1:0] st2, fa2;
`ifdef FA_FIRST_FAIL_CAPTURE_EN
    logic [2:0] fv1, fv2;
    logic       fs1, fc1, fval1, fs2, fc2, fval2;
`endif

    int         mode1, mode2;
    logic [7:0] ms1, mc1, ms2, mc2;
    int         checks, errors;
    logic [2:0] exp_q[$];

    // External full adder: mode 0 ideal, 1 S stuck at 0, 2 Cout inverted, 3 per-vector flip masks.
    function automatic logic [1:0] ext_fa(input logic [2:0] v, input int mode,
                                          input logic [7:0] ms, input logic [7:0] mc);
        int   sum;
        logic s, c;
        sum = int'(v[2]) + int'(v[1]) + int'(v[0]);
        s   = (sum % 2) == 1;
        c   = sum >= 2;
        case (mode)
            1: s = 1'b0;
            2: c = ~c;
            3: begin s = s ^ ms[v]; c = c ^ mc[v]; end
            default: ;
        endcase
        return {c, s};
    endfunction

    always_comb begin
        fa1 = ext_fa({a1, b1, ci1}, mode1, ms1, mc1);
        s1  = fa1[0];
        co1 = fa1[1];
        fa2 = ext_fa({a2, b2, ci2}, mode2, ms2, mc2);
        s2  = fa2[0];
        co2 = fa2[1];
    end

    fa_selftest_checker u_dut1 (
        .clk_input(clk), .reset_input(rst), .start_input(start1),
        .S_sense(s1), .Cout_sense(co1),
        .A_drive(a1), .B_drive(b1), .Cin_drive(ci1),
        .busy_output(busy1), .done_output(done1), .pass_output(pass1),
        .err_cnt_output(err1),
`ifdef FA_FIRST_FAIL_CAPTURE_EN
        .fail_vec_output(fv1), .fail_S_output(fs1), .fail_Cout_output(fc1),
        .fail_valid_output(fval1),
`endif
        .fsm_state_output(st1)
    );

    fa_selftest_checker #(.NUM_PASSES(2), .SETTLE_CYCLES(3), .ERR_CNT_W(2)) u_dut2 (
        .clk_input(clk), .reset_input(rst), .start_input(start2),
        .S_sense(s2), .Cout_sense(co2),
        .A_drive(a2), .B_drive(b2), .Cin_drive(ci2),
        .busy_output(busy2), .done_output(done2), .pass_output(pass2),
        .err_cnt_output(err2),
`ifdef FA_FIRST_FAIL_CAPTURE_EN
        .fail_vec_output(fv2), .fail_S_output(fs2), .fail_Cout_output(fc2),
        .fail_valid_output(fval2),
`endif
        .fsm_state_output(st2)
    );

    task automatic test_reset();
        rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
        #1;
        checks++;
        if ({a1, b1, ci1, busy1, done1, pass1, err1} !== 10'd0) begin
            errors++;
            $display("FAIL reset_inst1: got %b required 0", {a1, b1, ci1, busy1, done1, pass1, err1});
        end
        checks++;
        if ({a2, b2, ci2, busy2, done2, pass2, err2} !== 8'd0) begin
            errors++;
            $display("FAIL reset_inst2: got %b required 0", {a2, b2, ci2, busy2, done2, pass2, err2});
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One complete run on an instance; every expectation comes from the vector sweep rules.
    task automatic do_run(input int inst, input string name);
        int         np, sc, w, n, cnt, first_v, maxv, exp_err, m, got_err;
        logic [7:0] ms, mc;
        logic [2:0] e, got_v;
        logic [1:0] bad;
        logic       got_busy, got_done, got_pass;
        np = (inst == 1) ? 1 : 2;
        sc = (inst == 1) ? 1 : 3;
        w  = (inst == 1) ? 4 : 2;
        m  = (inst == 1) ? mode1 : mode2;
        ms = (inst == 1) ? ms1 : ms2;
        mc = (inst == 1) ? mc1 : mc2;
        n  = 8 * np * (sc + 1);
        cnt = 0; first_v = -1;
        for (int p = 0; p < np; p++)
            for (int v = 0; v < 8; v++)
                if (ext_fa(3'(v), m, ms, mc) != ext_fa(3'(v), 0, 8'd0, 8'd0)) begin
                    cnt++;
                    if (first_v < 0) first_v = v;
                end
        maxv    = (1 << w) - 1;
        exp_err = (cnt > maxv) ? maxv : cnt;
        exp_q.delete();
        for (int j = 0; j < n; j++) exp_q.push_back(3'((j / (sc + 1)) % 8));

        @(posedge clk); #1;
        if (inst == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        for (int j = 0; j < n; j++) begin
            e        = exp_q.pop_front();
            got_v    = (inst == 1) ? {a1, b1, ci1} : {a2, b2, ci2};
            got_busy = (inst == 1) ? busy1 : busy2;
            got_done = (inst == 1) ? done1 : done2;
            checks++;
            if ({got_busy, got_done, got_v} !== {1'b1, 1'b0, e}) begin
                errors++;
                $display("FAIL %s cyc%0d busy/done/vec: got %b required %b", name, j,
                         {got_busy, got_done, got_v}, {1'b1, 1'b0, e});
            end
            @(posedge clk); #1;
        end
        got_v    = (inst == 1) ? {a1, b1, ci1} : {a2, b2, ci2};
        got_busy = (inst == 1) ? busy1 : busy2;
        got_done = (inst == 1) ? done1 : done2;
        got_pass = (inst == 1) ? pass1 : pass2;
        got_err  = (inst == 1) ? int'(err1) : int'(err2);
        checks++;
        if ({got_busy, got_done, got_v} !== {1'b0, 1'b1, 3'd7}) begin
            errors++;
            $display("FAIL %s done_at_%0d busy/done/vec: got %b required 0_1_111", name, n,
                     {got_busy, got_done, got_v});
        end
        checks++;
        if (got_pass !== (cnt == 0)) begin
            errors++;
            $display("FAIL %s pass: got %b required %b", name, got_pass, cnt == 0);
        end
        checks++;
        if (got_err != exp_err) begin
            errors++;
            $display("FAIL %s err_cnt: got %0d required %0d", name, got_err, exp_err);
        end
`ifdef FA_FIRST_FAIL_CAPTURE_EN
        begin
            logic [5:0] got_f, exp_f;
            logic [1:0] fo;
            got_f = (inst == 1) ? {fval1, fv1, fs1, fc1} : {fval2, fv2, fs2, fc2};
            if (first_v < 0) exp_f = 6'd0;
            else begin
                fo    = ext_fa(3'(first_v), m, ms, mc);
                exp_f = {1'b1, 3'(first_v), fo[0], fo[1]};
            end
            checks++;
            if (got_f !== exp_f) begin
                errors++;
                $display("FAIL %s first_fail: got %b required %b", name, got_f, exp_f);
            end
        end
`endif
    endtask

    task automatic test_ideal();
        mode1 = 0; do_run(1, "ideal");
    endtask

    task automatic test_s_stuck();
        mode1 = 1; do_run(1, "s_stuck0");
    endtask

    task automatic test_cout_inv_saturate();
        mode2 = 2; do_run(2, "cout_inv_np2");
    endtask

    task automatic test_settle3();
        mode2 = 0; do_run(2, "settle3_ideal");
    endtask

    task automatic test_hold_done();
        int   k;
        logic p;
        p = pass1;
        k = $urandom_range(2, 6);
        repeat (k) @(posedge clk);
        #1;
        checks++;
        if ({done1, busy1, pass1, a1, b1, ci1} !== {1'b1, 1'b0, p, 3'd7}) begin
            errors++;
            $display("FAIL hold_done: got %b required %b", {done1, busy1, pass1, a1, b1, ci1},
                     {1'b1, 1'b0, p, 3'd7});
        end
    endtask

    task automatic test_back_to_back();
        mode1 = 1; do_run(1, "b2b_first");
        mode1 = 0; do_run(1, "b2b_restart");
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int inst;
            inst = $urandom_range(1, 2);
            if (inst == 1) begin
                mode1 = $urandom_range(0, 3); ms1 = 8'($urandom); mc1 = 8'($urandom);
            end else begin
                mode2 = $urandom_range(0, 3); ms2 = 8'($urandom); mc2 = 8'($urandom);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_run(inst, $sformatf("random%0d_inst%0d", r, inst));
        end
    endtask

    task automatic test_abort();
        mode1 = 0;
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            checks++;
            if ({busy1, a1, b1, ci1} !== {1'b1, 3'((j / 2) % 8)}) begin
                errors++;
                $display("FAIL abort_cyc%0d busy/vec: got %b required %b", j, {busy1, a1, b1, ci1},
                         {1'b1, 3'((j / 2) % 8)});
            end
            if (j == 5) start1 = 1'b1;
            if (j == 6) start1 = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({a1, b1, ci1, busy1, done1, pass1, err1} !== 10'd0) begin
            errors++;
            $display("FAIL abort_reset: got %b required 0", {a1, b1, ci1, busy1, done1, pass1, err1});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({a1, b1, ci1, busy1, done1, pass1} !== 6'd0) begin
            errors++;
            $display("FAIL abort_idle: got %b required 0", {a1, b1, ci1, busy1, done1, pass1});
        end
        do_run(1, "after_abort");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        mode1 = 0; mode2 = 0;
        ms1 = 8'd0; mc1 = 8'd0; ms2 = 8'd0; mc2 = 8'd0;
        test_reset();
        test_ideal();
        test_hold_done();
        test_s_stuck();
        test_cout_inv_saturate();
        test_settle3();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
